// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file definitions for the writeback scheduler: widths, the $zero
// index, the writeback request record and the round-robin index helper.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int RR_IDX_W   = 3;
    localparam int MAX_REQ    = 8;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Index following ptr in a ring of n requesters.
    function automatic logic [RR_IDX_W-1:0] next_rr(
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_IDX_W:0]   n
    );
        logic [RR_IDX_W:0] nxt;
        nxt = {1'b0, ptr} + 4'd1;
        return (nxt >= n) ? 3'd0 : nxt[RR_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting the scan at r_ptr, with the
// pointer moving one past the winner whenever any request is present.
module rr_arbiter
    import mips_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [RR_IDX_W-1:0] o_winner,
    output logic                o_found
);

    logic [RR_IDX_W-1:0] r_ptr;
    logic [RR_IDX_W-1:0] w_winner;
    logic                w_found;
    logic                w_hit;

    // Winner search: first the sources at or above r_ptr, then wrap to those below it.
    always_comb begin
        w_found  = 1'b0;
        w_winner = {RR_IDX_W{1'b0}};
        w_hit    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_hit    = !w_found && i_req[j] && (j >= int'(r_ptr));
            w_winner = w_hit ? RR_IDX_W'(j) : w_winner;
            w_found  = w_found || w_hit;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_hit    = !w_found && i_req[j] && (j < int'(r_ptr));
            w_winner = w_hit ? RR_IDX_W'(j) : w_winner;
            w_found  = w_found || w_hit;
        end
    end

    // One-hot grant decoded from the winning index.
    always_comb begin
        o_grant = {NUM_REQ{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = w_found && (w_winner == RR_IDX_W'(j));
        end
    end

    // Rotating priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (w_found) begin
            r_ptr <= next_rr(w_winner, 4'(NUM_REQ));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_winner = w_winner;
    assign o_found  = w_found;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler owning the regfile write port; decode-read bypass of the
// in-flight write is enabled by defining RF_WB_BYPASS_EN.
module regfile_wb_scheduler
    import mips_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    output logic [DATA_W-1:0]         rd_data1,
    output logic [DATA_W-1:0]         rd_data2,
    output logic [15:0]               grant_cnt
);

    logic [NUM_REQ-1:0]  w_grant;
    logic [RR_IDX_W-1:0] w_winner;
    logic                w_found;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [15:0]         r_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // The regfile never stalls, so every grant is a transfer; ready is held low in reset.
    assign req_ready = w_grant & {NUM_REQ{rst_n}};

    // AND-OR select of the granted source's address and data.
    always_comb begin
        w_sel_addr = {ADDR_W{1'b0}};
        w_sel_data = {DATA_W{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            w_sel_addr = w_sel_addr | (req_addr[j*ADDR_W +: ADDR_W] & {ADDR_W{w_grant[j]}});
            w_sel_data = w_sel_data | (req_data[j*DATA_W +: DATA_W] & {DATA_W{w_grant[j]}});
        end
    end

    // Write-port register; a $zero destination is consumed without raising the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
        end else if (w_found) begin
            r_we    <= (w_sel_addr != ADDR_W'(REG_ZERO));
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
            r_waddr <= r_waddr;
            r_wdata <= r_wdata;
        end
    end

    // Saturating count of accepted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_found && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign grant_cnt = r_cnt;

`ifdef RF_WB_BYPASS_EN
    // The regfile array still returns the old value this cycle, so forward the pending write.
    assign rd_data1 = (r_we && (r_waddr != ADDR_W'(REG_ZERO)) && (r_waddr == rd_addr1)) ? r_wdata : rf_rdata1;
    assign rd_data2 = (r_we && (r_waddr != ADDR_W'(REG_ZERO)) && (r_waddr == rd_addr2)) ? r_wdata : rf_rdata2;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign rd_data1 = rf_rdata1;
    assign rd_data2 = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a reference RR model predicts grants and the
// registered write one cycle later; predictions are queued and popped after each edge.
module tb_regfile_wb_scheduler;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [AW-1:0]     rd_addr1;
    logic [AW-1:0]     rd_addr2;
    logic [DW-1:0]     rf_rdata1;
    logic [DW-1:0]     rf_rdata2;
    logic [DW-1:0]     rd_data1;
    logic [DW-1:0]     rd_data2;
    logic [15:0]       grant_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t          sb[$];
    int            m_ptr;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    regfile_wb_scheduler #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[s]            = v;
        req_addr[s*AW +: AW]    = a;
        req_data[s*DW +: DW]    = d;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_cnt   = 16'd0;
        m_waddr = '0;
        m_wdata = '0;
        sb.delete();
    endtask

    // Called just after a negedge with inputs already driven; ends at the next negedge.
    task automatic step();
        exp_t          e;
        int            win;
        int            idx;
        logic [N-1:0]  er;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] x1;
        logic [DW-1:0] x2;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        check_eq("req_ready", req_ready, er);
        if (win >= 0) begin
            a = req_addr[win*AW +: AW];
            d = req_data[win*DW +: DW];
            e.we   = (a != 5'd0);
            e.addr = a;
            e.data = d;
            m_ptr  = (win + 1) % N;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_waddr = a;
            m_wdata = d;
        end else begin
            e.we   = 1'b0;
            e.addr = m_waddr;
            e.data = m_wdata;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("rf_we", rf_we, e.we);
        if (e.we) begin
            check_eq("rf_waddr", rf_waddr, e.addr);
            check_eq("rf_wdata", rf_wdata, e.data);
        end
        check_eq("grant_cnt", grant_cnt, m_cnt);
        x1 = (BYP && e.we && e.addr != 5'd0 && e.addr == rd_addr1) ? e.data : rf_rdata1;
        x2 = (BYP && e.we && e.addr != 5'd0 && e.addr == rd_addr2) ? e.data : rf_rdata2;
        check_eq("rd_data1", rd_data1, x1);
        check_eq("rd_data2", rd_data2, x2);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear_reqs();
        rd_addr1  = 5'd0;
        rd_addr2  = 5'd0;
        rf_rdata1 = 32'd0;
        rf_rdata2 = 32'd0;
        model_reset();

        // Reset with every source requesting.
        set_src(0, 1'b1, 5'd1, 32'h1111_0000);
        set_src(1, 1'b1, 5'd2, 32'h2222_0000);
        set_src(2, 1'b1, 5'd3, 32'h3333_0000);
        #3;
        check_eq("rst_ready", req_ready, 3'b000);
        check_eq("rst_we", rf_we, 1'b0);
        check_eq("rst_cnt", grant_cnt, 16'd0);
        @(posedge clk);
        #1;
        check_eq("rst_we_edge", rf_we, 1'b0);
        check_eq("rst_waddr", rf_waddr, 5'd0);
        check_eq("rst_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full load from reset: grant order 0,1,2,0,1,2 with back-to-back writes.
        repeat (6) step();

        // Single source.
        clear_reqs();
        set_src(1, 1'b1, 5'd8, 32'hDEADBEEF);
        step();
        clear_reqs();
        step();

        // $zero destination.
        set_src(0, 1'b1, 5'd0, 32'h0000_1234);
        step();
        clear_reqs();

        // Bypass of an in-flight write to r9.
        set_src(2, 1'b1, 5'd9, 32'hA5A5A5A5);
        rd_addr1  = 5'd9;
        rf_rdata1 = 32'd0;
        rd_addr2  = 5'd10;
        rf_rdata2 = 32'h5A5A_0F0F;
        step();
        check_eq("bypass_rd1", rd_data1, BYP ? 32'hA5A5A5A5 : 32'd0);
        check_eq("bypass_rd2", rd_data2, 32'h5A5A_0F0F);
        clear_reqs();

        // Two sources targeting the same register.
        set_src(0, 1'b1, 5'd12, 32'h0000_0111);
        set_src(1, 1'b1, 5'd12, 32'h0000_0222);
        step();
        step();
        clear_reqs();
        step();

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int s = 0; s < N; s++) begin
                set_src(s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom());
            end
            rd_addr1  = 5'($urandom_range(0, 4));
            rd_addr2  = 5'($urandom_range(0, 4));
            rf_rdata1 = $urandom();
            rf_rdata2 = $urandom();
            step();
        end

        // Reset between a transfer and its writeback edge.
        clear_reqs();
        set_src(0, 1'b1, 5'd3, 32'hCAFE_0001);
        step();
        set_src(1, 1'b1, 5'd4, 32'hCAFE_0002);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_we", rf_we, 1'b0);
        check_eq("midrst_ready", req_ready, 3'b000);
        check_eq("midrst_cnt", grant_cnt, 16'd0);
        @(posedge clk);
        #1;
        check_eq("midrst_we_edge", rf_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_src(0, 1'b1, 5'd5, 32'h0000_0A0A);
        set_src(2, 1'b1, 5'd6, 32'h0000_0B0B);
        step();
        clear_reqs();
        set_src(2, 1'b1, 5'd7, 32'h0000_0C0C);
        step();
        clear_reqs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
